// File: rtl/req_uart_tx.sv
// req_uart_tx: sends one fixed-byte UART frame for each rising edge of req.
// Rises that arrive while a frame is in flight are ignored and counted in drop_cnt.
module req_uart_tx #(
    parameter int unsigned CLK_DIV   = 16,
    parameter logic [7:0]  REQ_BYTE  = 8'hA5,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       req,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [7:0] drop_cnt
);
    localparam int unsigned       BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        logic p_s;
        p_s = ^data;
        return (mode == 32'd2) ? ~p_s : p_s;
    endfunction

    state_t            state_r;
    logic              req_d_r;
    logic [BAUD_W-1:0] baud_cnt_r;
    logic [2:0]        bit_idx_r;
    logic              stop_idx_r;
    logic [7:0]        shift_r;
    logic              tx_r;
    logic              busy_r;
    logic              done_r;
    logic [7:0]        drop_cnt_r;

    logic rise_s;
    logic baud_end_s;

    assign rise_s     = req & ~req_d_r;
    assign baud_end_s = (baud_cnt_r == BAUD_LAST);

    // Frame sequencer: bit timing, line level, busy and done flags
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            req_d_r    <= 1'b1;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            req_d_r <= req;
            done_r  <= 1'b0;
            if (baud_end_s || (state_r == ST_IDLE)) begin
                baud_cnt_r <= '0;
            end else begin
                baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    if (rise_s) begin
                        shift_r    <= REQ_BYTE;
                        bit_idx_r  <= 3'd0;
                        stop_idx_r <= 1'b0;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        tx_r    <= shift_r[0];
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        if (bit_idx_r == 3'd7) begin
                            if (PARITY != 32'd0) begin
                                tx_r    <= parity_bit(REQ_BYTE, PARITY);
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_end_s) begin
                        tx_r    <= 1'b1;
                        state_r <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // done is registered, so raise it one cycle ahead of the final stop cycle
                    if ((stop_idx_r == STOP_LAST) && (baud_cnt_r == BAUD_PRE)) begin
                        done_r <= 1'b1;
                    end
                    if (baud_end_s) begin
                        if (stop_idx_r == STOP_LAST) begin
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            stop_idx_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of request edges that land outside IDLE
    always_ff @(posedge clk) begin
        if (RST) begin
            drop_cnt_r <= 8'd0;
        end else if (rise_s && (state_r != ST_IDLE) && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign tx       = tx_r;
    assign tx_busy  = busy_r;
    assign tx_done  = done_r;
    assign drop_cnt = drop_cnt_r;

endmodule
